if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the RV32I pipeline. It owns the program counter, drives the synchronous instruction memory, and presents one fetched instruction per cycle, with its PC, on the IF/ID boundary, where the combinational control unit decodes it. It accepts a stall from the hazard logic and a taken branch/jump redirect from EX.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000 — first fetch address after reset; must be 4-byte aligned.

Ports (clock and reset):
- clk  in  1  — single clock; all state changes on its rising edge.
- rst_n  in  1  — asynchronous, active-low reset.

Control inputs:
- if_enable  in  1  — 1: IF/ID may advance; 0: stall and hold current IF/ID contents.
- redirect  in  1  — taken branch or jump resolved downstream.
- redirect_pc  in  32  — redirect target.

Instruction memory:
- inst_mem_enable  out  1  — read strobe.
- inst_mem_addr  out  32  — byte address of the read.
- inst_mem_rdata  in  32  — read data, valid exactly one cycle after a strobe cycle.

IF/ID outputs:
- if_id_valid  out  1  — IF/ID holds a live instruction.
- if_id_pc  out  32  — PC of that instruction.
- if_id_instruction  out  32  — instruction word to the control unit.

Status:
- misaligned  out  1  — sticky misaligned-redirect flag; tied 0 without the macro.

## Operation

- State machine: BOOT → RUN; with the macro also RUN → HALT. BOOT lasts exactly one cycle after reset release and issues no fetch.
- Registers: pc, resp_valid, resp_pc, hold_valid, hold_instr, state.
- Reset values: pc = RESET_PC, state = BOOT, resp_valid = 0, hold_valid = 0, misaligned = 0.
  - All outputs during and immediately after reset: inst_mem_enable = 0, if_id_valid = 0, if_id_pc = 0.
- Fetch issue in RUN:
  - inst_mem_enable = redirect | if_enable.
  - inst_mem_addr = redirect ? redirect_pc : pc.
  - On issue: pc ← addr + 4 (mod 2^32), resp_valid ← 1, resp_pc ← addr.
  - On no issue: resp_valid holds when it is being held, else clears.
- IF/ID output multiplexing:
  - if_id_instruction = hold_valid ? hold_instr : inst_mem_rdata.
  - if_id_pc = resp_pc.
  - if_id_valid = resp_valid & ~redirect.
- Stall (if_enable = 0, redirect = 0):
  - No fetch; pc holds.
  - If resp_valid & ~hold_valid: hold_instr ← inst_mem_rdata, hold_valid ← 1.
  - Output stays valid and unchanged for the whole stall.
- Stall release: the held instruction is consumed on the first if_enable = 1 edge, and hold_valid clears on that edge.
- Redirect:
  - Priority over stall.
  - The current IF/ID output is killed combinationally.
  - hold_valid clears.
  - The target is fetched in the same cycle.
- Wrap: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
- Asynchronous reset mid-operation:
  - All registers return to their reset values immediately.
  - Any in-flight response is discarded.

## Timing

- Reset release, cycle 0: BOOT, inst_mem_enable = 0.
- Cycle 1: inst_mem_enable = 1, address = RESET_PC.
- Cycle 2: if_id_valid = 1, if_id_pc = RESET_PC.
- Steady-state throughput: one instruction per cycle. Fetch-to-IF/ID latency: 1 cycle.
- Redirect penalty: the redirect cycle shows if_id_valid = 0; the target appears on IF/ID the following cycle.
- Stall timing: inst_mem_enable drops in the same cycle if_enable drops. Fetch resumes in the same cycle if_enable rises.
- No combinational path from inst_mem_rdata to inst_mem_addr.

## Configuration

- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0] ≠ 0 issues no fetch.
  - The block enters HALT and sets misaligned = 1.
  - In HALT, if_id_valid = 0 and inst_mem_enable = 0 until reset.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00.
  - HALT does not exist; misaligned is constant 0.

## Test plan

- Reset release, RESET_PC = 32'h100, if_enable = 1: strobes at 32'h100, 104, 108; if_id_pc sequence 32'h100, 104, 108 starting cycle 2; if_id_instruction matches the memory words.
- Stall for 3 cycles while IF/ID holds PC 32'h104: inst_mem_enable = 0 and the output stays 32'h104 with the same word; next cycle after release shows 32'h108.
- Redirect to 32'h200 in the cycle IF/ID shows 32'h108: if_id_valid = 0 that cycle, address = 32'h200; next cycle if_id_pc = 32'h200.
- Redirect asserted together with if_enable = 0: redirect wins; the target is fetched and hold is cleared.
- Redirect to 32'hFFFF_FFFC: the next fetch address is 32'h0.
- Redirect to 32'h203, macro defined: misaligned = 1 and if_id_valid stays 0. Macro undefined: fetch at 32'h200.
- Asynchronous reset pulse mid-stream: if_id_valid = 0 immediately; the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the synchronous instruction memory, feeds IF/ID.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises the sticky misaligned flag.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_enable,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_mem_enable,
    output logic [31:0] inst_mem_addr,
    input  logic [31:0] inst_mem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        misaligned
);

    // state | meaning
    // BOOT  | one idle cycle after reset release, no fetch issued
    // RUN   | fetching, one instruction per cycle unless stalled
    // HALT  | misaligned redirect seen, fetch stopped until reset (trap build only)
`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        hold_valid;
    logic [31:0] hold_instr;

    logic [31:0] target;
    logic        redirect_bad;
    logic        fetch;
    logic [31:0] fetch_addr;

`ifdef IF_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign target       = redirect_pc;
    assign redirect_bad = redirect & (|redirect_pc[1:0]);
    assign misaligned   = misaligned_q;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign target       = {redirect_pc[31:2], 2'b00};
    assign redirect_bad = 1'b0;
    assign misaligned   = 1'b0;
`endif

    // Address depends only on control inputs and pc, never on read data.
    assign fetch_addr      = redirect ? target : pc;
    assign fetch           = (state == RUN) & (redirect | if_enable) & ~redirect_bad;
    assign inst_mem_enable = fetch;
    assign inst_mem_addr   = fetch_addr;

    assign if_id_valid       = resp_valid & ~redirect;
    assign if_id_pc          = resp_pc;
    assign if_id_instruction = hold_valid ? hold_instr : inst_mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= 32'h0;
            hold_valid <= 1'b0;
            hold_instr <= 32'h0;
`ifdef IF_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
`ifdef IF_MISALIGN_TRAP_EN
                    if (redirect_bad) begin
                        state        <= HALT;
                        misaligned_q <= 1'b1;
                        resp_valid   <= 1'b0;
                        hold_valid   <= 1'b0;
                    end else
`endif
                    if (fetch) begin
                        pc         <= fetch_addr + 32'd4;
                        resp_valid <= 1'b1;
                        resp_pc    <= fetch_addr;
                        hold_valid <= 1'b0;
                    end else if (resp_valid && !hold_valid) begin
                        // Memory data is only valid one cycle; capture it for the rest of the stall.
                        hold_instr <= inst_mem_rdata;
                        hold_valid <= 1'b1;
                    end
                end
`ifdef IF_MISALIGN_TRAP_EN
                HALT: begin
                    resp_valid <= 1'b0;
                    hold_valid <= 1'b0;
                end
`endif
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for fetch/stall/redirect/wrap, plus an async reset sequence.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_mem_enable;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_enable(if_enable), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_mem_enable(inst_mem_enable), .inst_mem_addr(inst_mem_addr),
        .inst_mem_rdata(inst_mem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instruction(if_id_instruction), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // Synchronous memory; garbage when not strobed so a missing hold is visible.
    always @(posedge clk)
        inst_mem_rdata <= inst_mem_enable ? word(inst_mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ie;
        logic        rd;
        logic [31:0] rpc;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vec[20];

    initial begin
        //             ie    rd    rpc           en    addr          valid pc            mis
        vec[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vec[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,        1'b0};
        vec[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h100,      1'b0};
        vec[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104,      1'b0};
        vec[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104,      1'b0};
        vec[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104,      1'b0};
        vec[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 32'h104,      1'b0};
        vec[7]  = '{1'b1, 1'b1, 32'h200,      1'b1, 32'h200,      1'b0, 32'h0,        1'b0};
        vec[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h204,      1'b1, 32'h200,      1'b0};
        vec[9]  = '{1'b0, 1'b1, 32'h300,      1'b1, 32'h300,      1'b0, 32'h0,        1'b0};
        vec[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h300,      1'b0};
        vec[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h300,      1'b0};
        vec[12] = '{1'b0, 1'b1, 32'h400,      1'b1, 32'h400,      1'b0, 32'h0,        1'b0};
        vec[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h404,      1'b1, 32'h400,      1'b0};
        vec[14] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0};
        vec[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0};
        vec[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0,        1'b0};
`ifdef IF_MISALIGN_TRAP_EN
        vec[17] = '{1'b1, 1'b1, 32'h203,      1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vec[18] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        vec[19] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
`else
        vec[17] = '{1'b1, 1'b1, 32'h203,      1'b1, 32'h200,      1'b0, 32'h0,        1'b0};
        vec[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h204,      1'b1, 32'h200,      1'b0};
        vec[19] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h208,      1'b1, 32'h204,      1'b0};
`endif

        rst_n = 1'b0;
        if_enable = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_en", {31'b0, inst_mem_enable}, 32'h0);
        chk("reset_valid", {31'b0, if_id_valid}, 32'h0);
        chk("reset_pc", if_id_pc, 32'h0);
        chk("reset_mis", {31'b0, misaligned}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            if_enable   = vec[i].ie;
            redirect    = vec[i].rd;
            redirect_pc = vec[i].rpc;
            #1;
            chk($sformatf("v%0d_en", i), {31'b0, inst_mem_enable}, {31'b0, vec[i].e_en});
            if (vec[i].e_en)
                chk($sformatf("v%0d_addr", i), inst_mem_addr, vec[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vec[i].e_valid});
            if (vec[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), if_id_pc, vec[i].e_pc);
                chk($sformatf("v%0d_instr", i), if_id_instruction, word(vec[i].e_pc));
            end
            chk($sformatf("v%0d_mis", i), {31'b0, misaligned}, {31'b0, vec[i].e_mis});
        end

        // Async reset pulse mid-cycle, away from any clock edge.
        @(negedge clk);
        if_enable = 1'b1;
        redirect  = 1'b0;
        @(posedge clk);
        #2;
`ifdef IF_MISALIGN_TRAP_EN
        chk("pre_rst_valid", {31'b0, if_id_valid}, 32'h0);
`else
        chk("pre_rst_valid", {31'b0, if_id_valid}, 32'h1);
`endif
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("arst_en", {31'b0, inst_mem_enable}, 32'h0);
        chk("arst_pc", if_id_pc, 32'h0);
        chk("arst_mis", {31'b0, misaligned}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst2_c0_en", {31'b0, inst_mem_enable}, 32'h0);
        chk("rst2_c0_valid", {31'b0, if_id_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("rst2_c1_en", {31'b0, inst_mem_enable}, 32'h1);
        chk("rst2_c1_addr", inst_mem_addr, RPC);
        chk("rst2_c1_valid", {31'b0, if_id_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("rst2_c2_valid", {31'b0, if_id_valid}, 32'h1);
        chk("rst2_c2_pc", if_id_pc, RPC);
        chk("rst2_c2_instr", if_id_instruction, word(RPC));
        chk("rst2_c2_addr", inst_mem_addr, RPC + 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
